// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO peripheral-bus bridge.
package mmio_pkg;

   // Bridge sequencing: accept a request, run the bus cycle, hand back a response.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   // Peripheral window and well-known peripheral addresses.
   localparam logic [31:0] MMIO_BASE    = 32'h4000_0000;
   localparam logic [31:0] TIMER_ADDR   = 32'h4000_0004;
   localparam logic [3:0]  MMIO_TOP_DEF = 4'h4;

   // Payload returned on any error response (out of window or timeout).
   localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

   // One latched core request as it is presented on the peripheral bus.
   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } bus_req_t;

   // True when the address falls in the peripheral window selected by top.
   function automatic logic in_window(input logic [31:0] addr, input logic [3:0] top);
      return (addr[31:28] == top);
   endfunction

endpackage

// File: rtl/mmio_bridge_if.sv
// Core request/response channels plus the shared peripheral bus.
//
// Handshakes: a transfer happens on a rising clk edge where both valid and
// ready are high. Once valid is raised the sender holds it and its payload
// stable until that edge; ready may be raised or dropped freely.
interface mmio_bridge_if;

   // Core request channel.
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;

   // Core response channel.
   logic        resp_valid_o;
   logic        resp_ready_i;
   logic [31:0] resp_rdata_o;
   logic        resp_err_o;

   // Peripheral bus (strobes qualify addr/wdata; rdata/ack pulled low when idle).
   logic        write_o;
   logic        read_o;
   logic [31:0] addr_o;
   logic [31:0] wdata_o;
   logic [31:0] rdata_i;
   logic        ack_i;

   // Bridge view: accepts requests, masters the peripheral bus.
   modport master (
      input  req_valid_i, req_we_i, req_addr_i, req_wdata_i,
      output req_ready_o,
      output resp_valid_o, resp_rdata_o, resp_err_o,
      input  resp_ready_i,
      output write_o, read_o, addr_o, wdata_o,
      input  rdata_i, ack_i
   );

   // Environment view: the core plus the peripherals on the bus.
   modport slave (
      output req_valid_i, req_we_i, req_addr_i, req_wdata_i,
      input  req_ready_o,
      input  resp_valid_o, resp_rdata_o, resp_err_o,
      output resp_ready_i,
      input  write_o, read_o, addr_o, wdata_o,
      output rdata_i, ack_i
   );

endinterface

// File: rtl/mmio_timeout.sv
// Saturating up-counter that flags when a bus cycle has waited too long.
module mmio_timeout #(
   parameter int unsigned LIMIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CW = $clog2(LIMIT + 1);
   localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
   localparam logic [CW-1:0] MAX  = CW'(LIMIT);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Next count: clear wins, otherwise count up while enabled and stop at MAX.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (en_i && (count_q != MAX)) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Expired during the cycle whose closing edge would be the LIMIT-th wait.
   assign expired_o = (count_q >= LAST);

endmodule

// File: rtl/mmio_bridge.sv
// Single-outstanding bridge from the core load/store channel onto the
// memory-mapped peripheral bus, with window check and ack timeout.
module mmio_bridge
   import mmio_pkg::*;
#(
   parameter logic [3:0]  MMIO_TOP = MMIO_TOP_DEF,
   parameter int unsigned TIMEOUT  = 16,
   parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   mmio_bridge_if.master bus,
   output state_t        state_o
);

   state_t      state_q,      state_d;
   bus_req_t    issue_q,      issue_d;
   logic        write_q,      write_d;
   logic        read_q,       read_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q,   resp_err_d;

   logic        expired;
   logic        resp_hs;
   logic        req_hs;

   assign req_hs  = (state_q == IDLE) && bus.req_valid_i;
   assign resp_hs = (state_q == RESP) && bus.resp_ready_i;

   // Wait counter runs only while a bus cycle is outstanding; the response
   // handshake returns it to zero for the next transaction.
   mmio_timeout #(
      .LIMIT (TIMEOUT)
   ) u_timeout (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (resp_hs),
      .en_i      (state_q == ISSUE),
      .expired_o (expired)
   );

   // Next-state and next-output logic for the request/issue/response sequence.
   always_comb begin
      state_d      = state_q;
      issue_d      = issue_q;
      write_d      = write_q;
      read_d       = read_q;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;

      unique case (state_q)
         IDLE: begin
            if (req_hs) begin
               if (in_window(bus.req_addr_i, MMIO_TOP)) begin
                  // Only in-window requests touch the bus, so addr_o/wdata_o
                  // keep showing the last real bus cycle otherwise.
                  state_d       = ISSUE;
                  issue_d.we    = bus.req_we_i;
                  issue_d.addr  = bus.req_addr_i;
                  issue_d.wdata = bus.req_wdata_i;
                  write_d       = bus.req_we_i;
                  read_d        = !bus.req_we_i;
               end else begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_rdata_d = ERR_DATA;
                  resp_err_d   = 1'b1;
               end
            end
         end

         ISSUE: begin
            // Ack is checked first so an ack in the last allowed cycle still
            // completes the transaction normally.
            if (bus.ack_i) begin
               state_d      = RESP;
               write_d      = 1'b0;
               read_d       = 1'b0;
               resp_valid_d = 1'b1;
               resp_rdata_d = issue_q.we ? 32'h0 : bus.rdata_i;
               resp_err_d   = 1'b0;
            end else if (expired) begin
               state_d      = RESP;
               write_d      = 1'b0;
               read_d       = 1'b0;
               resp_valid_d = 1'b1;
               resp_rdata_d = ERR_DATA;
               resp_err_d   = 1'b1;
            end
         end

         RESP: begin
            if (bus.resp_ready_i) begin
               state_d      = IDLE;
               resp_valid_d = 1'b0;
            end
         end

         default: begin
            state_d = IDLE;
            write_d = 1'b0;
            read_d  = 1'b0;
         end
      endcase
   end

   // State and all registered bus/response outputs; reset drops strobes at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         issue_q      <= '0;
         write_q      <= 1'b0;
         read_q       <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'h0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         issue_q      <= issue_d;
         write_q      <= write_d;
         read_q       <= read_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign bus.req_ready_o  = (state_q == IDLE);
   assign bus.resp_valid_o = resp_valid_q;
   assign bus.resp_rdata_o = resp_rdata_q;
   assign bus.resp_err_o   = resp_err_q;
   assign bus.write_o      = write_q;
   assign bus.read_o       = read_q;
   assign bus.addr_o       = issue_q.addr;
   assign bus.wdata_o      = issue_q.wdata;
   assign state_o          = state_q;

endmodule
